uart_rx: RTL
============

# uart_rx

Serial 8N1 UART receiver for the FPGA top level. It is the receive-side counterpart of the `tx_data` transmitter. It oversamples the asynchronous `rx_data` line on the system clock, validates start and stop bits, and presents each received byte on a valid/ready handshake to the downstream command or DDR2 load logic. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200): clock cycles per bit. Must be even and ≥ 4.
- `clk` input 1: system clock. All logic is in this single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 1: asynchronous serial line. Idles high.
- `data_o` output 8: received byte, LSB first on the line.
- `valid_o` output 1: `data_o` holds an unconsumed byte.
- `ready_i` input 1: consumer accepts `data_o` when `ready_i` and `valid_o` are both high at a clk edge.
- `frame_err_o` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o` output 1: one-cycle pulse when a new byte overwrites an unconsumed byte.
- `busy_o` output 1: high in every state except IDLE.

## Operation
- `rx_data` passes through a 2-FF synchronizer. The second FF output is `rx_s`. Both FFs reset to 1.
- Let H = CLKS_PER_BIT/2 and C = CLKS_PER_BIT. Counter `cnt` is ceil(log2 C) bits wide and resets to 0 on every state change.
- State IDLE: when `rx_s` is 0, go to START.
- State START: at `cnt` = H-1, sample `rx_s`.
  - If 0, go to DATA (bit index 0).
  - If 1, treat it as a glitch and return to IDLE. No flags are raised.
- State DATA: at `cnt` = C-1, shift `rx_s` into bit[index] of the shift register and increment the index. After index 7 is sampled, go to STOP.
- State STOP: at `cnt` = C-1, sample `rx_s`.
  - If 1: load `data_o` from the shift register, set `valid_o`, and go to IDLE.
  - If 0: pulse `frame_err_o`, discard the byte, leave `data_o`/`valid_o` unchanged, and go to BREAK.
- State BREAK: stay until `rx_s` is 1, then go to IDLE. This prevents a held-low line or break condition from retriggering reception.
- Handshake:
  - `valid_o` and `data_o` stay stable until an edge where `valid_o` and `ready_i` are both high. `valid_o` clears after that edge unless a new byte completes on the same edge.
  - New byte completes while `valid_o` is high and `ready_i` is low: `data_o` takes the new byte, `valid_o` stays 1, and `overrun_o` pulses.
  - New byte completes on the same edge as an accept: `data_o` takes the new byte, `valid_o` stays 1, and no overrun is flagged.
- Reset values: state IDLE, `cnt` 0, `data_o` 0x00, `valid_o` 0, `frame_err_o` 0, `overrun_o` 0, `busy_o` 0.
- `rst` asserted mid-frame aborts the frame immediately. No flags are raised. After reset, the receiver resynchronizes on the next low level of `rx_s`.

## Timing
- Let E0 be the first clk edge that samples `rx_data` low.
  - `rx_s` is 0 after E0+1.
  - START is entered at E0+2.
  - Start bit is sampled at E0+2+H.
  - Data bit i is sampled at E0+2+H+(i+1)·C.
  - Stop bit is sampled at E0+2+H+9·C.
- `valid_o` and `data_o` update on the stop-sample edge.
- With C=16, `valid_o` rises 154 cycles after E0.
- `frame_err_o` and `overrun_o` are high for exactly one cycle, on the edge after the stop sample.
- `busy_o` is registered with the state and follows the state register with zero extra latency.
- Back-to-back frames: IDLE is entered on the stop-sample edge, so a start bit immediately following a stop bit of exactly C cycles is detected. No idle gap is required.
- Throughput is one byte per 10·C cycles. The consumer must accept within that window to avoid overrun.

## Test plan
- Use C=16.
  - Stimulus: drive 0xA5 (8N1) with `ready_i`=1.
  - Required response: `valid_o` high for exactly 1 cycle, 154 cycles after E0; `data_o`=0xA5; no flags.
- Use C=16 with `ready_i` held 0.
  - Stimulus: send 0x3C, then 0xC3 back-to-back.
  - Required response: after the first byte, `data_o`=0x3C and `valid_o` holds 1. After the second, `data_o`=0xC3 and `overrun_o` pulses for 1 cycle. Raising `ready_i` then clears `valid_o` the next cycle.
- Stimulus: send 0x55 with the stop bit driven low, then hold the line low for 40 cycles, then release it high.
  - Required response: `frame_err_o` pulses once; `valid_o` stays 0; `busy_o` stays high until the line goes high, then drops. A following 0x0F frame is received correctly.
- Stimulus: drive a 3-cycle low glitch on an idle line.
  - Required response: `busy_o` rises, then returns to 0 at the start-sample edge; no valid and no flags.
- Stimulus: assert `rst` for 1 cycle during data bit 4 of 0xFF, then send 0x81.
  - Required response: all outputs are 0 the cycle after reset; only 0x81 is delivered; no error flags.
- Stimulus: assert `ready_i` on the same edge that completes the next byte while `valid_o`=1.
  - Required response: `valid_o` stays 1, `data_o` shows the new byte, and `overrun_o` stays 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The line is synchronized, checked at mid-bit for
// start and stop, and each byte is offered downstream on a valid/ready handshake.
// A low stop bit parks the receiver in BREAK until the line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchronizer; resets high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with registered handshake, pulse flags and busy indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_o <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_o    <= shreg;
                            valid_o   <= 1'b1;
                            overrun_o <= valid_o && !ready_i;
                            state     <= IDLE;
                            busy_o    <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
